// File: rtl/fir_sequencer.sv
// -----------------------------------------------------------------------------
// fir_sequencer
//
// Sequences one pass of a 4-tap FIR filter over a stream of samples fetched
// from an external filter memory manager. The tap set is latched once per
// pass. Each sample is then requested, captured into the delay line and
// multiply-accumulated against the taps. A fixed-point result is strobed out
// for every sample. The pass ends on the sample flagged as last, or aborts
// with a sticky error if the memory manager does not answer within TIMEOUT
// cycles.
//
// Fixed point: b, m and result are Q(16-FRAC_BITS).FRAC_BITS two's complement.
//
// Optional feature macro: FIR_SEQ_SATURATE_EN
//   defined   -> result clamps to 16'h7FFF / 16'h8000 when the accumulator is
//                outside the 16-bit result range
//   undefined -> result is the plain accumulator bit slice (wraps)
//
// Parameters
//   FRAC_BITS            fraction bits of the fixed-point format (default 8)
//   TIMEOUT              maximum cycles spent waiting for a sample, 1..255
//
// Ports
//   clock                single clock, rising edge
//   clear                asynchronous active-high reset
//   start                begin a pass (sampled only when idle)
//   mgr_en               enable to the memory manager while a pass is active
//   b_element_ready      tap set valid and stable
//   b0..b3_element       filter taps
//   m_element_requested  one-cycle request for the next sample
//   m_element_ready      sample valid this cycle
//   m_element            input sample
//   last_m_element       marks m_element as the final sample of the pass
//   result_valid         one-cycle strobe, result holds a new output
//   result               filter output
//   sample_count         results produced this pass (wraps 1023 -> 0)
//   busy                 high whenever not idle
//   done                 one-cycle strobe at pass completion
//   error                sticky timeout flag
// -----------------------------------------------------------------------------
module fir_sequencer #(
    parameter int FRAC_BITS = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    output logic        mgr_en,
    input  logic        b_element_ready,
    input  logic [15:0] b0_element,
    input  logic [15:0] b1_element,
    input  logic [15:0] b2_element,
    input  logic [15:0] b3_element,
    output logic        m_element_requested,
    input  logic        m_element_ready,
    input  logic [15:0] m_element,
    input  logic        last_m_element,
    output logic        result_valid,
    output logic [15:0] result,
    output logic [9:0]  sample_count,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_B,
        REQUEST,
        WAIT_M,
        MAC,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Latched tap set and sample delay line (x0 is the newest sample)
    logic signed [15:0] b0;
    logic signed [15:0] b1;
    logic signed [15:0] b2;
    logic signed [15:0] b3;
    logic signed [15:0] x0;
    logic signed [15:0] x1;
    logic signed [15:0] x2;
    logic signed [15:0] x3;
    logic               last_flag;

    // Cycles spent in WAIT_M so far; the timeout fires on the last allowed one
    logic [7:0] wait_count;
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    logic timeout_hit;

    logic signed [31:0] p0;
    logic signed [31:0] p1;
    logic signed [31:0] p2;
    logic signed [31:0] p3;
    logic signed [33:0] acc;
    logic        [15:0] result_next;

    assign timeout_hit = (wait_count == TIMEOUT_LAST);

    // State register
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the state-decoded outputs
    always_comb begin
        state_next          = state;
        mgr_en              = 1'b0;
        m_element_requested = 1'b0;
        busy                = 1'b1;
        done                = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = LOAD_B;
                end
            end
            LOAD_B: begin
                mgr_en = 1'b1;
                if (b_element_ready) begin
                    state_next = REQUEST;
                end
            end
            REQUEST: begin
                mgr_en              = 1'b1;
                m_element_requested = 1'b1;
                state_next          = WAIT_M;
            end
            WAIT_M: begin
                mgr_en = 1'b1;
                if (m_element_ready) begin
                    state_next = MAC;
                end else if (timeout_hit) begin
                    // Abort straight to IDLE: no done pulse on a timeout
                    state_next = IDLE;
                end
            end
            MAC: begin
                mgr_en     = 1'b1;
                state_next = last_flag ? DONE : REQUEST;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Four signed 16x16 products summed at 34 bits so the sum cannot overflow
    always_comb begin
        p0  = b0 * x0;
        p1  = b1 * x1;
        p2  = b2 * x2;
        p3  = b3 * x3;
        acc = {{2{p0[31]}}, p0} + {{2{p1[31]}}, p1}
            + {{2{p2[31]}}, p2} + {{2{p3[31]}}, p3};
    end

`ifdef FIR_SEQ_SATURATE_EN
    // Clamp when the realigned accumulator no longer fits in 16 signed bits
    logic signed [33:0] acc_shifted;

    always_comb begin
        acc_shifted = acc >>> FRAC_BITS;
        if (acc_shifted > 34'sd32767) begin
            result_next = 16'h7FFF;
        end else if (acc_shifted < -34'sd32768) begin
            result_next = 16'h8000;
        end else begin
            result_next = acc_shifted[15:0];
        end
    end
`else
    // Plain realignment: keep bits FRAC_BITS+15 .. FRAC_BITS, overflow wraps
    always_comb begin
        result_next = 16'(acc >>> FRAC_BITS);
    end
`endif

    // Datapath: tap latch, delay line, timeout counter, result and status
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            b0           <= '0;
            b1           <= '0;
            b2           <= '0;
            b3           <= '0;
            x0           <= '0;
            x1           <= '0;
            x2           <= '0;
            x3           <= '0;
            last_flag    <= 1'b0;
            wait_count   <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            sample_count <= '0;
            error        <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Fresh pass: warm-up outputs see zeros for missing samples
                        x0           <= '0;
                        x1           <= '0;
                        x2           <= '0;
                        x3           <= '0;
                        last_flag    <= 1'b0;
                        sample_count <= '0;
                        error        <= 1'b0;
                    end
                end
                LOAD_B: begin
                    if (b_element_ready) begin
                        b0 <= b0_element;
                        b1 <= b1_element;
                        b2 <= b2_element;
                        b3 <= b3_element;
                    end
                end
                REQUEST: begin
                    wait_count <= '0;
                end
                WAIT_M: begin
                    if (m_element_ready) begin
                        x0        <= m_element;
                        last_flag <= last_m_element;
                    end else if (timeout_hit) begin
                        error <= 1'b1;
                    end else begin
                        wait_count <= wait_count + 8'd1;
                    end
                end
                MAC: begin
                    result       <= result_next;
                    result_valid <= 1'b1;
                    x1           <= x0;
                    x2           <= x1;
                    x3           <= x2;
                    sample_count <= sample_count + 10'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fir_sequencer
//
// Directed testbench for fir_sequencer. Every pass is driven from tables of
// taps, samples and hand-computed expected results in Q8.8. The expected
// values for the overflow case depend on FIR_SEQ_SATURATE_EN.
// -----------------------------------------------------------------------------
module tb_fir_sequencer;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic        mgr_en;
    logic        b_element_ready = 1'b0;
    logic [15:0] b0_element = '0;
    logic [15:0] b1_element = '0;
    logic [15:0] b2_element = '0;
    logic [15:0] b3_element = '0;
    logic        m_element_requested;
    logic        m_element_ready = 1'b0;
    logic [15:0] m_element = '0;
    logic        last_m_element = 1'b0;
    logic        result_valid;
    logic [15:0] result;
    logic [9:0]  sample_count;
    logic        busy;
    logic        done;
    logic        error;

    int checkCount = 0;
    int errorCount = 0;
    int doneCount  = 0;
    int validCount = 0;

    logic [15:0] tapVec[4];
    logic [15:0] sampleVec[8];
    logic [15:0] expectVec[8];
    int          numSamples;

    fir_sequencer #(.FRAC_BITS(8), .TIMEOUT(255)) dut (
        .clock               (clock),
        .clear               (clear),
        .start               (start),
        .mgr_en              (mgr_en),
        .b_element_ready     (b_element_ready),
        .b0_element          (b0_element),
        .b1_element          (b1_element),
        .b2_element          (b2_element),
        .b3_element          (b3_element),
        .m_element_requested (m_element_requested),
        .m_element_ready     (m_element_ready),
        .m_element           (m_element),
        .last_m_element      (last_m_element),
        .result_valid        (result_valid),
        .result              (result),
        .sample_count        (sample_count),
        .busy                (busy),
        .done                (done),
        .error               (error)
    );

    always #5 clock = ~clock;

    // Count strobes on the falling edge so every pulse is seen exactly once
    always @(negedge clock) begin
        if (done) doneCount++;
        if (result_valid) validCount++;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Runs one complete pass from the tables, checking every result
    task automatic applyStimulus(input string name, input bit holdStart,
                                 input bit spuriousReady);
        int startDone;
        int startValid;
        int waited;
        startDone  = doneCount;
        startValid = validCount;
        start = 1'b1;
        tick;
        if (!holdStart) start = 1'b0;
        checkOutput($sformatf("%s mgr_en in LOAD_B", name), 32'(mgr_en), 32'd1);
        b0_element      = tapVec[0];
        b1_element      = tapVec[1];
        b2_element      = tapVec[2];
        b3_element      = tapVec[3];
        b_element_ready = 1'b1;
        tick;
        // Taps must already be latched; scramble the inputs
        b_element_ready = 1'b0;
        b0_element      = 16'hDEAD;
        b1_element      = 16'hBEEF;
        b2_element      = 16'h1234;
        b3_element      = 16'h4321;
        for (int i = 0; i < numSamples; i++) begin
            waited = 0;
            while (!m_element_requested && waited < 20) begin
                tick;
                waited++;
            end
            checkOutput($sformatf("%s request %0d", name, i),
                        32'(m_element_requested), 32'd1);
            if (!m_element_requested) begin
                start = 1'b0;
                return;
            end
            if (spuriousReady) begin
                m_element_ready = 1'b1;
                m_element       = 16'h7000;
                last_m_element  = 1'b1;
            end
            tick;
            m_element_ready = 1'b0;
            last_m_element  = 1'b0;
            checkOutput($sformatf("%s request one cycle %0d", name, i),
                        32'(m_element_requested), 32'd0);
            for (int k = 0; k < i % 3; k++) tick;
            m_element       = sampleVec[i];
            last_m_element  = (i == numSamples - 1);
            m_element_ready = 1'b1;
            tick;
            m_element_ready = 1'b0;
            last_m_element  = 1'b0;
            m_element       = 16'h5555;
            tick;
            checkOutput($sformatf("%s result_valid %0d", name, i),
                        32'(result_valid), 32'd1);
            checkOutput($sformatf("%s result %0d", name, i),
                        32'(result), 32'(expectVec[i]));
        end
        checkOutput($sformatf("%s done", name), 32'(done), 32'd1);
        checkOutput($sformatf("%s sample_count", name),
                    32'(sample_count), 32'(numSamples));
        start = 1'b0;
        tick;
        checkOutput($sformatf("%s busy after done", name), 32'(busy), 32'd0);
        tick;
        checkOutput($sformatf("%s result held", name),
                    32'(result), 32'(expectVec[numSamples - 1]));
        checkOutput($sformatf("%s still idle", name), 32'(busy), 32'd0);
        checkOutput($sformatf("%s done pulses", name),
                    32'(doneCount - startDone), 32'd1);
        checkOutput($sformatf("%s valid pulses", name),
                    32'(validCount - startValid), 32'(numSamples));
    endtask

    // Tap b0 = 1.0 only, samples 1.0, 2.0, 3.0
    task automatic loadSimplePass;
        tapVec    = '{16'h0100, 16'h0000, 16'h0000, 16'h0000};
        sampleVec = '{16'h0100, 16'h0200, 16'h0300, 0, 0, 0, 0, 0};
        expectVec = '{16'h0100, 16'h0200, 16'h0300, 0, 0, 0, 0, 0};
        numSamples = 3;
    endtask

    int waited;
    int doneBefore;

    initial begin
        // Reset state
        tick;
        tick;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset mgr_en", 32'(mgr_en), 32'd0);
        checkOutput("reset result", 32'(result), 32'd0);
        checkOutput("reset sample_count", 32'(sample_count), 32'd0);
        checkOutput("reset error", 32'(error), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        clear = 1'b0;
        tick;

        loadSimplePass();
        applyStimulus("single tap", 1'b0, 1'b0);

        // All taps 1.0, constant 1.0 input: warm-up ramp
        tapVec    = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        sampleVec = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 0, 0, 0, 0};
        expectVec = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 0, 0, 0, 0};
        numSamples = 4;
        applyStimulus("ramp", 1'b0, 1'b0);

        // Taps 1,2,3,4 and samples 1,2,3,4,-2 check delay-line ordering and sign
        tapVec    = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
        sampleVec = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'hFE00, 0, 0, 0};
        expectVec = '{16'h0100, 16'h0400, 16'h0A00, 16'h1400, 16'h1700, 0, 0, 0};
        numSamples = 5;
        applyStimulus("distinct taps", 1'b0, 1'b0);

        // Positive overflow
        tapVec    = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        sampleVec = '{16'h7FFF, 16'h7FFF, 0, 0, 0, 0, 0, 0};
`ifdef FIR_SEQ_SATURATE_EN
        expectVec = '{16'h7FFF, 16'h7FFF, 0, 0, 0, 0, 0, 0};
`else
        expectVec = '{16'hFF00, 16'hFE00, 0, 0, 0, 0, 0, 0};
`endif
        numSamples = 2;
        applyStimulus("overflow pos", 1'b0, 1'b0);

        // Negative overflow: -128.0 * 127.996
        tapVec    = '{16'h8000, 16'h0000, 16'h0000, 16'h0000};
        sampleVec = '{16'h7FFF, 0, 0, 0, 0, 0, 0, 0};
`ifdef FIR_SEQ_SATURATE_EN
        expectVec = '{16'h8000, 0, 0, 0, 0, 0, 0, 0};
`else
        expectVec = '{16'h0080, 0, 0, 0, 0, 0, 0, 0};
`endif
        numSamples = 1;
        applyStimulus("overflow neg", 1'b0, 1'b0);

        // Timeout: request but never answer
        doneBefore = doneCount;
        start = 1'b1;
        tick;
        start = 1'b0;
        b0_element      = 16'h0100;
        b_element_ready = 1'b1;
        tick;
        b_element_ready = 1'b0;
        checkOutput("timeout request", 32'(m_element_requested), 32'd1);
        waited = 0;
        while (busy && waited < 400) begin
            tick;
            waited++;
        end
        checkOutput("timeout cycles", 32'(waited), 32'd256);
        checkOutput("timeout error", 32'(error), 32'd1);
        checkOutput("timeout busy", 32'(busy), 32'd0);
        checkOutput("timeout mgr_en", 32'(mgr_en), 32'd0);
        tick;
        checkOutput("timeout error sticky", 32'(error), 32'd1);
        checkOutput("timeout no done", 32'(doneCount - doneBefore), 32'd0);
        start = 1'b1;
        tick;
        start = 1'b0;
        checkOutput("error cleared by start", 32'(error), 32'd0);
        clear = 1'b1;
        tick;
        clear = 1'b0;
        tick;

        // Clear during WAIT_M of the second sample, then a full pass
        loadSimplePass();
        doneBefore = doneCount;
        start = 1'b1;
        tick;
        start = 1'b0;
        b0_element      = tapVec[0];
        b1_element      = tapVec[1];
        b2_element      = tapVec[2];
        b3_element      = tapVec[3];
        b_element_ready = 1'b1;
        tick;
        b_element_ready = 1'b0;
        tick;
        m_element       = sampleVec[0];
        m_element_ready = 1'b1;
        tick;
        m_element_ready = 1'b0;
        tick;
        checkOutput("abort first result", 32'(result), 32'h0100);
        checkOutput("abort second request", 32'(m_element_requested), 32'd1);
        tick;
        #2;
        clear = 1'b1;
        #1;
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort mgr_en", 32'(mgr_en), 32'd0);
        checkOutput("abort result", 32'(result), 32'd0);
        checkOutput("abort sample_count", 32'(sample_count), 32'd0);
        checkOutput("abort result_valid", 32'(result_valid), 32'd0);
        tick;
        clear = 1'b0;
        tick;
        checkOutput("abort no done", 32'(doneCount - doneBefore), 32'd0);
        applyStimulus("after clear", 1'b0, 1'b0);

        // start held high and a stray ready during REQUEST
        loadSimplePass();
        applyStimulus("start held", 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
